// File: rtl/int_event_pkg.sv
// Shared constants for the interrupt event latch: channel mode encodings
// and the register word map of the 16-bit configuration bus.
package int_event_pkg;

  localparam int NUM_CH = 32;
  localparam int BUS_W  = 16;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_RISE  = 2'b01,
    MODE_FALL  = 2'b10,
    MODE_LEVEL = 2'b11
  } modeT;

  localparam logic [2:0] A_MODE0  = 3'd0;
  localparam logic [2:0] A_MODE1  = 3'd1;
  localparam logic [2:0] A_MODE2  = 3'd2;
  localparam logic [2:0] A_MODE3  = 3'd3;
  localparam logic [2:0] A_OVF_LO = 3'd4;
  localparam logic [2:0] A_OVF_HI = 3'd5;
  localparam logic [2:0] A_LVL_LO = 3'd6;
  localparam logic [2:0] A_LVL_HI = 3'd7;

endpackage

// File: rtl/int_event_chan.sv
// One interrupt channel: 3-flop synchronizer, mode-qualified event detect,
// sticky pending bit and overflow flag.
module int_event_chan
  import int_event_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic intIn,
  input  modeT mode,
  input  logic clr,
  input  logic ovfClr,
  output logic status,
  output logic ovf,
  output logic level
);

  logic s1;
  logic s2;
  logic s3;
  logic evt;

  always_comb begin
    evt = 1'b0;
    case (mode)
      MODE_RISE:  evt = s2 & ~s3;
      MODE_FALL:  evt = ~s2 & s3;
      MODE_LEVEL: evt = s2;
      default:    evt = 1'b0;
    endcase
  end

  // Sets dominate clears for both the pending bit and the overflow flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      status <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      s1     <= intIn;
      s2     <= s1;
      s3     <= s2;
      status <= (status & ~clr) | evt;
      ovf    <= (ovf & ~ovfClr) | (evt & status & ~clr);
    end
  end

  assign level = s2;

endmodule

// File: rtl/int_event_latch.sv
// Interrupt path front end: 32 event channels plus the mode registers,
// write decode and combinational read mux of the 16-bit register bus.
module int_event_latch
  import int_event_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [2:0]  Addr,
  output logic [15:0] DataRd,
  input  logic [15:0] DataWr,
  input  logic        En,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [31:0] IntIn,
  input  logic [31:0] IntReset,
  output logic [31:0] IntStatus
);

  logic [15:0] modeWord [4];
  logic [31:0] ovfVec;
  logic [31:0] levelVec;
  logic [31:0] ovfClrVec;
  logic        wrStrobe;

  // Reads have no side effects, so the read strobe is intentionally unused.
  logic unusedRd;
  assign unusedRd = Rd;

  assign wrStrobe = Wr & En;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < 4; k++) modeWord[k] <= '0;
    end else if (wrStrobe && !Addr[2]) begin
      modeWord[Addr[1:0]] <= DataWr;
    end
  end

  always_comb begin
    ovfClrVec = '0;
    if (wrStrobe) begin
      if (Addr == A_OVF_LO) ovfClrVec[15:0]  = DataWr;
      if (Addr == A_OVF_HI) ovfClrVec[31:16] = DataWr;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : gChan
    modeT chMode;
    assign chMode = modeT'(modeWord[ch / 8][2 * (ch % 8) +: 2]);

    int_event_chan uChan (
      .Clk    (Clk),
      .Reset  (Reset),
      .intIn  (IntIn[ch]),
      .mode   (chMode),
      .clr    (IntReset[ch]),
      .ovfClr (ovfClrVec[ch]),
      .status (IntStatus[ch]),
      .ovf    (ovfVec[ch]),
      .level  (levelVec[ch])
    );
  end

  always_comb begin
    DataRd = '0;
    case (Addr)
      A_MODE0:  DataRd = modeWord[0];
      A_MODE1:  DataRd = modeWord[1];
      A_MODE2:  DataRd = modeWord[2];
      A_MODE3:  DataRd = modeWord[3];
      A_OVF_LO: DataRd = ovfVec[15:0];
      A_OVF_HI: DataRd = ovfVec[31:16];
      A_LVL_LO: DataRd = levelVec[15:0];
      A_LVL_HI: DataRd = levelVec[31:16];
      default:  DataRd = '0;
    endcase
  end

endmodule

// File: tb/tb_int_event_latch.sv
// Self-checking bench for int_event_latch: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_int_event_latch;

  logic        Clk;
  logic        Reset;
  logic [2:0]  Addr;
  logic [15:0] DataRd;
  logic [15:0] DataWr;
  logic        En;
  logic        Rd;
  logic        Wr;
  logic [31:0] IntIn;
  logic [31:0] IntReset;
  logic [31:0] IntStatus;

  int passed = 0;
  int total  = 0;

  int_event_latch dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Addr      (Addr),
    .DataRd    (DataRd),
    .DataWr    (DataWr),
    .En        (En),
    .Rd        (Rd),
    .Wr        (Wr),
    .IntIn     (IntIn),
    .IntReset  (IntReset),
    .IntStatus (IntStatus)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural model: hist[k] is the IntIn value sampled k+1 edges ago.
  logic [1:0]  mMode [32];
  logic [31:0] mStat;
  logic [31:0] mOvf;
  logic [31:0] hist [3];
  logic        modelValid = 1'b0;
  logic [31:0] cur, prv;
  logic        ev, ovfClrBit;

  always @(posedge Clk) begin
    if (Reset) begin
      for (int c = 0; c < 32; c++) mMode[c] = 2'b00;
      mStat = '0;
      mOvf  = '0;
      for (int k = 0; k < 3; k++) hist[k] = '0;
      modelValid = 1'b1;
    end else begin
      cur = hist[1];
      prv = hist[2];
      for (int c = 0; c < 32; c++) begin
        case (mMode[c])
          2'b01:   ev = cur[c] && !prv[c];
          2'b10:   ev = !cur[c] && prv[c];
          2'b11:   ev = cur[c];
          default: ev = 1'b0;
        endcase
        ovfClrBit = Wr && En && (((Addr == 3'd4) && (c < 16) && DataWr[c % 16]) ||
                                 ((Addr == 3'd5) && (c >= 16) && DataWr[c % 16]));
        if (ev && mStat[c] && !IntReset[c]) mOvf[c] = 1'b1;
        else if (ovfClrBit) mOvf[c] = 1'b0;
        if (ev) mStat[c] = 1'b1;
        else if (IntReset[c]) mStat[c] = 1'b0;
      end
      if (Wr && En && (Addr < 3'd4))
        for (int i = 0; i < 8; i++) mMode[Addr * 8 + i] = DataWr[2 * i +: 2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = IntIn;
    end
  end

  function automatic logic [15:0] modelRead(input logic [2:0] a);
    logic [15:0] w;
    w = '0;
    if (a < 3'd4) begin
      for (int i = 0; i < 8; i++) w[2 * i +: 2] = mMode[a * 8 + i];
    end else if (a == 3'd4) w = mOvf[15:0];
    else if (a == 3'd5) w = mOvf[31:16];
    else if (a == 3'd6) w = hist[1][15:0];
    else w = hist[1][31:16];
    return w;
  endfunction

  // Scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge Clk) begin
    #1;
    if (modelValid) begin
      check("model_status", IntStatus, mStat);
      check("model_datard", {16'h0, DataRd}, {16'h0, modelRead(Addr)});
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic busWrite(input logic [2:0] a, input logic [15:0] d);
    Addr = a; DataWr = d; Wr = 1'b1; En = 1'b1;
    tick(1);
    Wr = 1'b0; En = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [2:0] a, input logic [15:0] exp);
    Addr = a; Rd = 1'b1; En = 1'b1;
    #1;
    check(name, {16'h0, DataRd}, {16'h0, exp});
    Rd = 1'b0; En = 1'b0;
  endtask

  task automatic pulseClr(input logic [31:0] m);
    IntReset = m;
    tick(1);
    IntReset = '0;
  endtask

  initial begin
    Reset = 1'b1; Addr = '0; DataWr = '0; En = 1'b0; Rd = 1'b0; Wr = 1'b0;
    IntIn = '0; IntReset = '0;
    tick(2);
    check("reset_status", IntStatus, 32'h0);
    check("reset_datard", {16'h0, DataRd}, 32'h0);
    Reset = 1'b0;

    // ch0 rising: status appears on the third edge after the input change
    busWrite(3'd0, 16'h0001);
    IntIn[0] = 1'b1;
    tick(2);
    check("rise_latency_early", {31'h0, IntStatus[0]}, 32'h0);
    tick(1);
    check("rise_set", {31'h0, IntStatus[0]}, 32'h1);
    pulseClr(32'h0000_0001);
    check("rise_clear", {31'h0, IntStatus[0]}, 32'h0);
    tick(3);
    check("rise_no_reset_high", {31'h0, IntStatus[0]}, 32'h0);

    // ch1 falling
    busWrite(3'd0, 16'h0008);
    IntIn[1] = 1'b1;
    tick(4);
    check("fall_ignore_rise", {31'h0, IntStatus[1]}, 32'h0);
    IntIn[1] = 1'b0;
    tick(2);
    check("fall_latency_early", {31'h0, IntStatus[1]}, 32'h0);
    tick(1);
    check("fall_set", {31'h0, IntStatus[1]}, 32'h1);
    pulseClr(32'h0000_0002);
    check("fall_clear", {31'h0, IntStatus[1]}, 32'h0);

    // ch16 level
    busWrite(3'd2, 16'h0003);
    IntIn[16] = 1'b1;
    tick(3);
    check("level_set", {31'h0, IntStatus[16]}, 32'h1);
    pulseClr(32'h0001_0000);
    check("level_clear_blocked", {31'h0, IntStatus[16]}, 32'h1);
    IntIn[16] = 1'b0;
    tick(3);
    pulseClr(32'h0001_0000);
    check("level_clear", {31'h0, IntStatus[16]}, 32'h0);
    readCheck("level_ovf_hi", 3'd5, 16'h0001);
    busWrite(3'd5, 16'h0001);
    readCheck("level_ovf_hi_w1c", 3'd5, 16'h0000);

    // ch0 overflow and W1C
    busWrite(3'd0, 16'h0001);
    IntIn[0] = 1'b0; tick(3);
    IntIn[0] = 1'b1; tick(3);
    check("ovf_first_set", {31'h0, IntStatus[0]}, 32'h1);
    readCheck("ovf_none_yet", 3'd4, 16'h0000);
    IntIn[0] = 1'b0; tick(3);
    IntIn[0] = 1'b1; tick(3);
    readCheck("ovf_lo_set", 3'd4, 16'h0001);
    busWrite(3'd4, 16'h0001);
    readCheck("ovf_lo_w1c", 3'd4, 16'h0000);
    pulseClr(32'h0000_0001);
    check("ovf_status_clear", {31'h0, IntStatus[0]}, 32'h0);
    IntIn[0] = 1'b0; tick(3);
    IntIn[0] = 1'b1; tick(2);
    pulseClr(32'h0000_0001);
    check("set_wins_clear", {31'h0, IntStatus[0]}, 32'h1);
    readCheck("set_clear_no_ovf", 3'd4, 16'h0000);

    // all modes off, raw level readback
    for (int k = 0; k < 4; k++) busWrite(k[2:0], 16'h0000);
    pulseClr(32'hFFFF_FFFF);
    IntIn = 32'hA5A5_0F0F;
    tick(2);
    readCheck("lvl_lo", 3'd6, 16'h0F0F);
    readCheck("lvl_hi", 3'd7, 16'hA5A5);
    tick(3);
    check("modes_off_status", IntStatus, 32'h0);
    busWrite(3'd7, 16'hFFFF);
    readCheck("lvl_hi_ro", 3'd7, 16'hA5A5);

    // reset with live state
    busWrite(3'd1, 16'hFFFF);
    tick(3);
    check("pre_reset_status", IntStatus, 32'h0000_0F00);
    readCheck("pre_reset_ovf", 3'd4, 16'h0F00);
    Reset = 1'b1;
    tick(1);
    check("mid_reset_status", IntStatus, 32'h0);
    readCheck("mid_reset_mode1", 3'd1, 16'h0000);
    readCheck("mid_reset_ovf", 3'd4, 16'h0000);
    readCheck("mid_reset_lvl", 3'd6, 16'h0000);
    Reset = 1'b0;
    busWrite(3'd0, 16'h0055);
    tick(2);
    check("post_reset_rise", IntStatus, 32'h0000_000F);
    tick(3);
    check("post_reset_hold", IntStatus, 32'h0000_000F);
    readCheck("post_reset_no_ovf", 3'd4, 16'h0000);

    tick(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
